bcd_countdown_core: RTL and testbench

//  - Holds an MM:SS countdown value as four packed BCD digits; decrements by one second per tick.
//  - Feeds the display/compare path with a clean, always-valid BCD value.
//  - Drives a one-cycle done pulse at zero for the alarm/stop logic.
//  - Digit-serial borrow arithmetic; no binary intermediate is stored.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/bcd_digit_dec.sv | 29 ++
 rtl/bcd_countdown_core.sv | 136 +++++++++++++
 tb/tb_bcd_countdown_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD countdown core.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } cd_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX      = 4'd9;
   localparam bcd_digit_t SEC_TENS_DEF = 4'd5;

   // A digit is acceptable when it is plain BCD and within its positional limit.
   function automatic logic digit_ok(input bcd_digit_t d, input bcd_digit_t max_val);
      return (d <= BCD_MAX) && (d <= max_val);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow chain: decrements when borrowed from, wraps to
// max_val and borrows from the next digit up when it is already zero.
module bcd_digit_dec
   import stopwatch_pkg::*;
(
   input  bcd_digit_t digit_in,
   input  bcd_digit_t max_val,
   input  logic       borrow_in,
   output bcd_digit_t digit_out,
   output logic       borrow_out
);

   // Decrement-with-borrow for a single digit.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      digit_out  = digit_in;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit_in == 4'd0) begin
            digit_out  = max_val;
            borrow_out = 1'b1;
         end else begin
            digit_out  = digit_in - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_countdown_core.sv
// MM:SS countdown held as four packed BCD digits. Control FSM, load
// validator, digit-serial decrement chain and registered status pulses.
module bcd_countdown_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned MIN_TENS_MAX = 9,
   parameter int unsigned SEC_TENS_MAX = 5
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] count,
   output logic        running,
   output logic        done,
   output logic        load_err
);

   localparam bcd_digit_t MIN_TENS_LIM = bcd_digit_t'(MIN_TENS_MAX);
   localparam bcd_digit_t SEC_TENS_LIM = bcd_digit_t'(SEC_TENS_MAX);

   cd_state_t   state_q, state_d;
   logic [15:0] count_q, count_d;
   logic        done_q, done_d;
   logic        load_err_q, load_err_d;

   // Decremented value of the current count; only committed on a RUN tick.
   logic [15:0] dec_count;
   logic [3:0]  borrow;
   logic        dec_is_zero;
   logic        load_ok;

   // Borrow chain, least significant digit first. The seconds-units digit
   // always borrows so the chain output is count - 1 second.
   bcd_digit_dec u_sec_units (
      .digit_in   (count_q[3:0]),
      .max_val    (BCD_MAX),
      .borrow_in  (1'b1),
      .digit_out  (dec_count[3:0]),
      .borrow_out (borrow[0])
   );

   bcd_digit_dec u_sec_tens (
      .digit_in   (count_q[7:4]),
      .max_val    (SEC_TENS_LIM),
      .borrow_in  (borrow[0]),
      .digit_out  (dec_count[7:4]),
      .borrow_out (borrow[1])
   );

   bcd_digit_dec u_min_units (
      .digit_in   (count_q[11:8]),
      .max_val    (BCD_MAX),
      .borrow_in  (borrow[1]),
      .digit_out  (dec_count[11:8]),
      .borrow_out (borrow[2])
   );

   // RUN never holds 00:00, so the minutes-tens wrap value is never committed.
   bcd_digit_dec u_min_tens (
      .digit_in   (count_q[15:12]),
      .max_val    (MIN_TENS_LIM),
      .borrow_in  (borrow[2]),
      .digit_out  (dec_count[15:12]),
      .borrow_out (borrow[3])
   );

   assign dec_is_zero = (dec_count == 16'h0000);

   // A preset is accepted only outside RUN and only if every digit is legal.
   assign load_ok = (state_q != RUN)
                 && digit_ok(load_val[3:0],   BCD_MAX)
                 && digit_ok(load_val[7:4],   SEC_TENS_LIM)
                 && digit_ok(load_val[11:8],  BCD_MAX)
                 && digit_ok(load_val[15:12], MIN_TENS_LIM);

   // Next-state logic: one command per cycle, clear > load > stop > start > tick.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (clear) begin
         count_d = 16'h0000;
         state_d = IDLE;
      end else if (load) begin
         if (load_ok) begin
            count_d = load_val;
            state_d = IDLE;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (stop) begin
         if (state_q == RUN) begin
            state_d = PAUSED;
         end
      end else if (start) begin
         if (((state_q == IDLE) || (state_q == PAUSED)) && (count_q != 16'h0000)) begin
            state_d = RUN;
         end
      end else if (tick && (state_q == RUN)) begin
         count_d = dec_count;
         if (dec_is_zero) begin
            done_d  = 1'b1;
            state_d = DONE;
         end
      end
   end

   // State, count and pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= 16'h0000;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         done_q     <= done_d;
         load_err_q <= load_err_d;
      end
   end

   assign count    = count_q;
   assign running  = (state_q == RUN);
   assign done     = done_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_core.sv
// Self-checking bench for bcd_countdown_core: directed steps followed by a
// randomized phase, all compared against a seconds-based reference model.
module tb_bcd_countdown_core;

   localparam int S_IDLE   = 0;
   localparam int S_RUN    = 1;
   localparam int S_PAUSED = 2;
   localparam int S_DONE   = 3;

   logic        clk = 1'b0;
   logic        rst, tick, start, stop, clear, load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        running, done, load_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: remaining time in whole seconds plus a state number.
   int   m_secs;
   int   m_st;
   logic m_done;
   logic m_lerr;

   always #5 clk = ~clk;

   bcd_countdown_core dut (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .running  (running),
      .done     (done),
      .load_err (load_err)
   );

   function automatic bit legal_val(input logic [15:0] v);
      int d0, d1, d2, d3;
      d0 = int'(v[3:0]);
      d1 = int'(v[7:4]);
      d2 = int'(v[11:8]);
      d3 = int'(v[15:12]);
      return (d0 <= 9) && (d1 <= 5) && (d2 <= 9) && (d3 <= 9);
   endfunction

   function automatic int bcd_to_secs(input logic [15:0] v);
      return int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] secs_to_bcd(input int s);
      int mm, ss;
      logic [3:0] a, b, c, d;
      mm = s / 60;
      ss = s % 60;
      a = 4'(mm / 10);
      b = 4'(mm % 10);
      c = 4'(ss / 10);
      d = 4'(ss % 10);
      return {a, b, c, d};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, t, sa, so, c, l, input logic [15:0] v);
      m_done = 1'b0;
      m_lerr = 1'b0;
      if (r) begin
         m_secs = 0;
         m_st   = S_IDLE;
      end else if (c) begin
         m_secs = 0;
         m_st   = S_IDLE;
      end else if (l) begin
         if (m_st != S_RUN && legal_val(v)) begin
            m_secs = bcd_to_secs(v);
            m_st   = S_IDLE;
         end else begin
            m_lerr = 1'b1;
         end
      end else if (so) begin
         if (m_st == S_RUN) m_st = S_PAUSED;
      end else if (sa) begin
         if ((m_st == S_IDLE || m_st == S_PAUSED) && m_secs != 0) m_st = S_RUN;
      end else if (t && m_st == S_RUN) begin
         m_secs = m_secs - 1;
         if (m_secs == 0) begin
            m_done = 1'b1;
            m_st   = S_DONE;
         end
      end
   endtask

   // One clock cycle: drive inputs, advance the model, sample after the edge.
   task automatic cycle(input string tag, input logic r, t, sa, so, c, l,
                        input logic [15:0] v);
      rst = r; tick = t; start = sa; stop = so; clear = c; load = l; load_val = v;
      model_step(r, t, sa, so, c, l, v);
      @(posedge clk);
      #1;
      check({tag, ".count"},    count,             secs_to_bcd(m_secs));
      check({tag, ".running"},  {15'd0, running},  {15'd0, (m_st == S_RUN)});
      check({tag, ".done"},     {15'd0, done},     {15'd0, m_done});
      check({tag, ".load_err"}, {15'd0, load_err}, {15'd0, m_lerr});
      rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
   endtask

   // Argument order for cycle(): tag, rst, tick, start, stop, clear, load, load_val.
   initial begin
      int op;
      logic [15:0] v;
      rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
      load_val = 16'h0000;
      m_secs = 0; m_st = S_IDLE; m_done = 1'b0; m_lerr = 1'b0;

      cycle("reset0", 1, 0, 0, 0, 0, 0, 16'h0000);
      cycle("reset1", 1, 0, 0, 0, 0, 0, 16'h0000);
      cycle("idle",   0, 1, 0, 0, 0, 0, 16'h0000);

      // Full run from 01:30 down to zero.
      cycle("load0130",  0, 0, 0, 0, 0, 1, 16'h0130);
      cycle("start0130", 0, 0, 1, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 90; i++) cycle("run0130", 0, 1, 0, 0, 0, 0, 16'h0000);
      cycle("after_done", 0, 1, 0, 0, 0, 0, 16'h0000);
      cycle("start_in_done", 0, 0, 1, 0, 0, 0, 16'h0000);

      // Borrow ripples through every digit.
      cycle("load1000",  0, 0, 0, 0, 0, 1, 16'h1000);
      cycle("start1000", 0, 0, 1, 0, 0, 0, 16'h0000);
      cycle("tick1000",  0, 1, 0, 0, 0, 0, 16'h0000);
      check("ripple_0959", count, 16'h0959);

      // Illegal presets while paused.
      cycle("stop0959", 0, 0, 0, 1, 0, 0, 16'h0000);
      cycle("bad0060",  0, 0, 0, 0, 0, 1, 16'h0060);
      cycle("bad00A0",  0, 0, 0, 0, 0, 1, 16'h00A0);
      cycle("badA000",  0, 0, 0, 0, 0, 1, 16'hA000);

      // stop wins over a same-cycle tick.
      cycle("load0005",  0, 0, 0, 0, 0, 1, 16'h0005);
      cycle("start0005", 0, 0, 1, 0, 0, 0, 16'h0000);
      cycle("stop_tick", 0, 1, 0, 1, 0, 0, 16'h0000);
      check("stop_tick_hold", count, 16'h0005);
      cycle("resume", 0, 0, 1, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 5; i++) cycle("run0005", 0, 1, 0, 0, 0, 0, 16'h0000);
      cycle("post0005", 0, 0, 0, 0, 0, 0, 16'h0000);

      // start at zero is ignored.
      cycle("clear0",  0, 0, 0, 0, 1, 0, 16'h0000);
      cycle("start0",  0, 0, 1, 0, 0, 0, 16'h0000);

      // Load during RUN is rejected and the countdown carries on.
      cycle("load0004",  0, 0, 0, 0, 0, 1, 16'h0004);
      cycle("start0004", 0, 0, 1, 0, 0, 0, 16'h0000);
      cycle("load_run",  0, 0, 0, 0, 0, 1, 16'h0100);
      cycle("tick0004",  0, 1, 0, 0, 0, 0, 16'h0000);
      check("run_at_0003", count, 16'h0003);

      // clear beats a same-cycle tick.
      cycle("clear_tick", 0, 1, 0, 0, 1, 0, 16'h0000);

      // Reset mid-RUN with a tick in flight.
      cycle("load0200",  0, 0, 0, 0, 0, 1, 16'h0200);
      cycle("start0200", 0, 0, 1, 0, 0, 0, 16'h0000);
      cycle("tick0200",  0, 1, 0, 0, 0, 0, 16'h0000);
      cycle("rst_run",   1, 1, 0, 0, 0, 0, 16'h0000);

      // Randomized command mix, short presets so runs reach zero often.
      for (int i = 0; i < 1500; i++) begin
         op = $urandom_range(0, 31);
         if (op < 14)       cycle("rnd_tick",  0, 1, 0, 0, 0, 0, 16'h0000);
         else if (op < 17)  cycle("rnd_start", 0, 0, 1, 0, 0, 0, 16'h0000);
         else if (op < 19)  cycle("rnd_stop",  0, 0, 0, 1, 0, 0, 16'h0000);
         else if (op == 19) cycle("rnd_clear", 0, 0, 0, 0, 1, 0, 16'h0000);
         else if (op < 23) begin
            v = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                 4'($urandom_range(0, 9))};
            cycle("rnd_load", 0, 0, 0, 0, 0, 1, v);
         end else if (op == 23) begin
            v = 16'($urandom);
            cycle("rnd_rawload", 0, 0, 0, 0, 0, 1, v);
         end else if (op == 24) cycle("rnd_rst", 1, 0, 0, 0, 0, 0, 16'h0000);
         else               cycle("rnd_none", 0, 0, 0, 0, 0, 0, 16'h0000);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
